// File: rtl/alu_sequencer_if.sv
// Instruction-memory read bus between alu_sequencer (master) and the byte memory (slave).
// mem_req/mem_addr are driven by the master; mem_rdata/mem_ack are returned by memory.
interface alu_sequencer_if;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for the 8-bit accumulator ALU: fetches {opcode, operand}, drives the ALU,
// commits to acc/pc. Optional macro INSTR_COUNT_EN adds the 16-bit retired-instruction counter.
module alu_sequencer #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned HALT_BIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  alu_sequencer_if.master   mem,
  output logic [1:0]        alu_ctrl,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [7:0]        alu_pc,
  input  logic [7:0]        alu_result,
  output logic [7:0]        acc,
  output logic [7:0]        pc,
  output logic              halted,
  input  logic              resume
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]       retired
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH_OP  = 3'd1;
  localparam logic [2:0] S_FETCH_ARG = 3'd2;
  localparam logic [2:0] S_EXEC      = 3'd3;
  localparam logic [2:0] S_HALT      = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] pc_plus1, pc_plus2;
  logic       halt_entry;

  assign pc_plus1   = pc_q + 8'd1;
  assign pc_plus2   = pc_q + 8'd2;
  assign halt_entry = (state_q == S_FETCH_OP) && mem.mem_ack && mem.mem_rdata[HALT_BIT];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH_OP;
      S_FETCH_OP: begin
        if (mem.mem_ack) begin
          opcode_d = mem.mem_rdata;
          state_d  = mem.mem_rdata[HALT_BIT] ? S_HALT : S_FETCH_ARG;
        end
      end
      S_FETCH_ARG: begin
        if (mem.mem_ack) begin
          operand_d = mem.mem_rdata;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        // Branch returns the new pc from the ALU; every other op writes the accumulator.
        if (opcode_q[1:0] == 2'b10) begin
          pc_d = alu_result;
        end else begin
          acc_d = alu_result;
          pc_d  = pc_plus2;
        end
        state_d = S_FETCH_OP;
      end
      S_HALT: begin
        if (resume) begin
          pc_d    = pc_plus1;
          state_d = S_FETCH_OP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      acc_q     <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
    end
  end

  // Bus outputs decode registered state only, so they cannot glitch on mem_ack/mem_rdata.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_addr = '0;
    case (state_q)
      S_FETCH_OP: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = pc_q;
      end
      S_FETCH_ARG: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = pc_plus1;
      end
      default: begin
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
      end
    endcase
  end

  assign alu_ctrl = opcode_q[1:0];
  assign alu_a    = acc_q;
  assign alu_b    = operand_q;
  assign alu_pc   = pc_plus2;
  assign acc      = acc_q;
  assign pc       = pc_q;
  assign halted   = (state_q == S_HALT);

`ifdef INSTR_COUNT_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if ((state_q == S_EXEC) || halt_entry) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  logic unused_halt_entry;
  assign unused_halt_entry = halt_entry;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: instruction-level reference model feeds an expected
// queue of memory reads; an independent monitor checks bus, acc/pc and EXEC-cycle ALU drive.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sequencer_if bus();

  logic [1:0] alu_ctrl;
  logic [7:0] alu_a, alu_b, alu_pc, alu_result, acc, pc;
  logic       halted, resume;
`ifdef INSTR_COUNT_EN
  logic [15:0] retired;
`endif

  alu_sequencer #(.RESET_PC(8'h00), .HALT_BIT(7)) dut (
    .clk        (clk),
    .reset      (rst),
    .mem        (bus),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_pc     (alu_pc),
    .alu_result (alu_result),
    .acc        (acc),
    .pc         (pc),
    .halted     (halted),
    .resume     (resume)
`ifdef INSTR_COUNT_EN
    ,
    .retired    (retired)
`endif
  );

  // Combinational ALU seen by the sequencer.
  always_comb begin
    case (alu_ctrl)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = ~(alu_a & alu_b);
      2'b10:   alu_result = (alu_a != 8'd0) ? alu_b : alu_pc;
      default: alu_result = (alu_a < alu_b) ? 8'd1 : 8'd0;
    endcase
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Memory image and bus behaviour knobs.
  logic [7:0] mem_arr [256];
  int         wait_mode   = 0;   // <0: random 0..3 wait cycles, else fixed count
  bit         spurious_en = 0;
  int         hold_target = 5;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  acc;
    logic [7:0]  pc;
    logic [15:0] ret;
    bit          is_arg;
    bit          is_halt;
    logic [1:0]  ctrl;
    logic [7:0]  b;
  } exp_t;

  exp_t q[$];

  // Instruction-level interpreter: one expected record per memory read the program makes.
  task automatic build_expect(input int n);
    logic [7:0]  p, a, op, arg, pa;
    logic [15:0] r;
    exp_t        e;
    p = 8'h00; a = 8'h00; r = 16'd0;
    for (int k = 0; k < n; k++) begin
      op = mem_arr[p];
      e.addr = p; e.acc = a; e.pc = p; e.ret = r;
      e.is_arg = 0; e.is_halt = op[7]; e.ctrl = 2'b00; e.b = 8'h00;
      q.push_back(e);
      if (op[7]) begin
        p = p + 8'd1;
      end else begin
        pa  = p + 8'd1;
        arg = mem_arr[pa];
        e.addr = pa; e.is_arg = 1; e.is_halt = 0; e.ctrl = op[1:0]; e.b = arg;
        q.push_back(e);
        case (op[1:0])
          2'b00: a = a + arg;
          2'b01: a = ~(a & arg);
          2'b11: a = (a < arg) ? 8'd1 : 8'd0;
          default: ;
        endcase
        if (op[1:0] == 2'b10) p = (a != 8'd0) ? arg : p + 8'd2;
        else                  p = p + 8'd2;
      end
      r = r + 16'd1;
    end
  endtask

  // Memory responder: waits are drawn per request; optional stray acks while idle.
  initial begin
    int  cnt;
    bit  busy;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    busy = 0;
    cnt  = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        if (!busy) begin
          busy = 1;
          cnt  = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        end
        if (cnt == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_arr[bus.mem_addr];
          busy = 0;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 8'($urandom);
          cnt--;
        end
      end else begin
        busy = 0;
        if (spurious_en && ($urandom % 4 == 0)) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = 8'($urandom);
        end else begin
          bus.mem_ack   = 1'b0;
        end
      end
    end
  end

  // Resume driver: releases HALT after hold_target cycles, random noise elsewhere.
  initial begin
    int hcnt;
    hcnt   = 0;
    resume = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (halted && !rst) begin
        hcnt++;
        check("halt_req_low", bus.mem_req, 1'b0);
        resume = (hcnt >= hold_target);
      end else begin
        hcnt   = 0;
        resume = ($urandom % 4 == 0);
      end
    end
  end

  // Monitor: pops one expectation per accepted read.
  initial begin
    exp_t       e;
    int         cyc, prev_cyc;
    bit         pend, have_prev, prev_arg, prev_wait;
    logic [7:0] prev_addr, x_ctrl_b, x_a, x_pc;
    logic [1:0] x_ctrl;
    cyc = 0; prev_cyc = 0; pend = 0; have_prev = 0; prev_arg = 0; prev_wait = 0;
    prev_addr = 8'h00; x_ctrl_b = 8'h00; x_a = 8'h00; x_pc = 8'h00; x_ctrl = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend = 0; have_prev = 0; prev_wait = 0;
        continue;
      end
      if (pend) begin
        check("exec_ctrl", alu_ctrl, x_ctrl);
        check("exec_b", alu_b, x_ctrl_b);
        check("exec_a", alu_a, x_a);
        check("exec_pc2", alu_pc, x_pc);
        check("exec_req_low", bus.mem_req, 1'b0);
        pend = 0;
      end
      if (prev_wait) begin
        check("wait_req_held", bus.mem_req, 1'b1);
        check("wait_addr_stable", bus.mem_addr, prev_addr);
      end
      prev_wait = bus.mem_req && !bus.mem_ack;
      prev_addr = bus.mem_addr;
      if (bus.mem_req && bus.mem_ack && q.size() > 0) begin
        e = q.pop_front();
        check("rd_addr", bus.mem_addr, e.addr);
        check("rd_acc", acc, e.acc);
        check("rd_pc", pc, e.pc);
`ifdef INSTR_COUNT_EN
        check("rd_retired", retired, e.ret);
`endif
        if (wait_mode == 0 && have_prev)
          check("zero_wait_gap", cyc - prev_cyc, prev_arg ? 2 : 1);
        if (e.is_arg) begin
          pend = 1; x_ctrl = e.ctrl; x_ctrl_b = e.b; x_a = e.acc; x_pc = e.pc + 8'd2;
        end
        have_prev = !e.is_halt;
        prev_cyc  = cyc;
        prev_arg  = e.is_arg;
      end
    end
  end

  task automatic do_reset(input int n, input int ninstr);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("rst_req", bus.mem_req, 1'b0);
      check("rst_pc", pc, 8'h00);
      check("rst_acc", acc, 8'h00);
      check("rst_halted", halted, 1'b0);
`ifdef INSTR_COUNT_EN
      check("rst_retired", retired, 16'd0);
`endif
    end
    q.delete();
    build_expect(ninstr);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_low", bus.mem_req, 1'b0);
    @(negedge clk);
    check("first_fetch_req", bus.mem_req, 1'b1);
    check("first_fetch_addr", bus.mem_addr, 8'h00);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && q.size() > 0; i++) @(negedge clk);
    check("drain_queue", q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
  endtask

  initial begin
    logic [7:0] b;
    bit         found;
    rst = 1'b1;

    // Directed: add/add, branch taken, SLT, NAND, add to zero, branch not taken, HALT.
    clear_mem();
    mem_arr[8'h00] = 8'h00; mem_arr[8'h01] = 8'h05;
    mem_arr[8'h02] = 8'h00; mem_arr[8'h03] = 8'h03;
    mem_arr[8'h04] = 8'h02; mem_arr[8'h05] = 8'h20;
    mem_arr[8'h20] = 8'h00; mem_arr[8'h21] = 8'hFB;
    mem_arr[8'h22] = 8'h03; mem_arr[8'h23] = 8'h07;
    mem_arr[8'h24] = 8'h01; mem_arr[8'h25] = 8'hFF;
    mem_arr[8'h26] = 8'h00; mem_arr[8'h27] = 8'h02;
    mem_arr[8'h28] = 8'h02; mem_arr[8'h29] = 8'h40;
    mem_arr[8'h2A] = 8'h80;
    wait_mode = 0; spurious_en = 0; hold_target = 5;
    do_reset(3, 12);
    wait_done(2000);

    // Random programs, random waits, stray acks, resume noise.
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 256; i++) begin
        b = 8'($urandom);
        if ($urandom % 8 != 0) b[7] = 1'b0;
        mem_arr[i] = b;
      end
      wait_mode   = (s % 2 == 1) ? -1 : 0;
      spurious_en = 1;
      hold_target = int'($urandom_range(1, 6));
      do_reset(int'($urandom_range(1, 3)), 40);
      wait_done(3000);
    end

    // pc wrap: HALT at FE, resume to FF, operand fetched from 00, 4-cycle waits.
    clear_mem();
    mem_arr[8'h00] = 8'h00; mem_arr[8'h01] = 8'h01;
    mem_arr[8'h02] = 8'h02; mem_arr[8'h03] = 8'hFE;
    mem_arr[8'hFE] = 8'h80; mem_arr[8'hFF] = 8'h00;
    wait_mode = 4; spurious_en = 1; hold_target = 3;
    do_reset(2, 8);
    wait_done(3000);

    // Reset in the middle of a waiting fetch.
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = bus.mem_req && !bus.mem_ack && (pc != 8'h00);
    end
    check("midwait_found", found, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midwait_rst_pc", pc, 8'h00);
    check("midwait_rst_acc", acc, 8'h00);
    check("midwait_rst_req", bus.mem_req, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midwait_post_req_low", bus.mem_req, 1'b0);
    @(negedge clk);
    check("midwait_refetch_addr", bus.mem_addr, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that sequences the 8-bit accumulator ALU. Fetches two-byte instructions (opcode, operand) from a byte memory over a req/ack handshake, then drives the ALU control, operand and pc inputs. Commits the ALU result to the accumulator or the program counter. Sits between instruction memory and the ALU; owns the architectural acc and pc registers.

Parameters:
RESET_PC, 8'h00, pc value loaded on reset
HALT_BIT, 7, opcode bit that marks a one-byte HALT instruction

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock (clk), sampled on rising edge of clk
mem_req  output  1  memory read request
mem_addr  output  8  byte address, stable while mem_req high
mem_rdata  input  8  read data, valid in the cycle mem_ack is high
mem_ack  input  1  read complete; sampled only while mem_req high
alu_ctrl  output  2  ALU op: 00 add, 01 nand, 10 branch-not-zero, 11 set-less-than
alu_a  output  8  ALU accumulator operand (= acc)
alu_b  output  8  ALU data operand (latched operand byte)
alu_pc  output  8  ALU pc input (= pc+2 mod 256)
alu_result  input  8  combinational ALU output
acc  output  8  accumulator register
pc  output  8  program counter
halted  output  1  high while in S_HALT
resume  input  1  leave S_HALT

Behaviour:
- Reset (sync, active-high): state=S_IDLE, pc=RESET_PC, acc=0, opcode=0, operand=0, mem_req=0, mem_addr=0, halted=0. Holding reset keeps S_IDLE. Reset mid-transaction abandons it; the in-flight ack is ignored.
- S_IDLE: mem_req=0. Next cycle go to S_FETCH_OP.
- S_FETCH_OP: mem_req=1, mem_addr=pc.
  - On ack: latch opcode=mem_rdata.
  - If mem_rdata[HALT_BIT]=1, go to S_HALT. Otherwise go to S_FETCH_ARG.
- S_FETCH_ARG: mem_req=1, mem_addr=pc+1 (wraps FF->00).
  - On ack: latch operand=mem_rdata, go to S_EXEC.
- S_EXEC: mem_req=0. alu_ctrl=opcode[1:0], alu_a=acc, alu_b=operand, alu_pc=pc+2.
  - ctrl 00/01/11: acc<=alu_result, pc<=pc+2.
  - ctrl 10: pc<=alu_result (ALU returns operand if acc!=0, else pc+2); acc unchanged.
  - Go to S_FETCH_OP.
- S_HALT: mem_req=0, halted=1. On resume=1: pc<=pc+1 (HALT is one byte), go to S_FETCH_OP. resume is ignored in every other state.
- Handshake:
  - mem_req and mem_addr are decoded from registered state, so they are glitch-free.
  - Request held until ack. Ack may arrive in the first request cycle (zero-wait).
  - Ack while mem_req=0 is ignored.
  - mem_req drops in the cycle after the accepting edge whenever the next state is non-fetch.
  - Back-to-back FETCH_OP->FETCH_ARG keeps mem_req high with a new address.
- Latency: zero-wait memory gives 3 cycles per ALU instruction (OP, ARG, EXEC). Each wait cycle adds 1.
- Arithmetic: all pc math is mod 256 (pc=FE gives EXEC pc+2=00; pc=FF gives arg address 00). Add wraps mod 256, no carry kept.
- alu_ctrl/alu_b hold their latched values outside S_EXEC. acc/pc change only in S_EXEC or on HALT resume.
- opcode bits other than [1:0] and HALT_BIT are reserved and ignored.

Optional Feature:
INSTR_COUNT_EN
- Defined: adds output retired[15:0]. Reset to 0; increments by 1 on every S_EXEC cycle and every HALT entry; wraps FFFF->0000.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset held 3 cycles, then released -> mem_req=0 during reset and first post-reset cycle. Next cycle mem_req=1, mem_addr=00. acc=00, pc=00.
2. Mem {00:00,01:05,02:00,03:03}, zero-wait -> after 6 cycles acc=08, pc=04. alu_ctrl=00 in both EXEC cycles.
3. acc=08; instr at 04 = {02, 20} -> pc=20. Same instruction with acc=00 -> pc=06.
4. acc=03; instr {03,07} then {01,FF} -> acc=01 after the SLT, then acc=FE after the NAND.
5. Opcode 80 at pc=10 -> halted=1, mem_req=0 held; resume after 5 cycles -> pc=11, fetch resumes at 11. retired incremented by 1 when INSTR_COUNT_EN is defined.
6. Ack delayed 4 cycles in FETCH_ARG, pc=FF -> mem_addr=00 held stable with mem_req=1 throughout. Spurious ack in S_EXEC ignored. Reset asserted mid-wait returns to S_IDLE, pc=00.
